mc_controller: RTL and testbench

Multicycle control unit for the 32-bit MIPS-subset datapath. It sequences fetch, decode, execute, memory and writeback through a Moore state machine. It drives every datapath mux select and write enable, and derives the 3-bit ALU `sel` from opcode and funct. It sits beside the datapath and consumes only `op`, `funct` and the ALU `zero` flag.

---
 rtl/mc_pkg.sv | 58 +++++
 rtl/mc_alu_dec.sv | 28 ++
 rtl/mc_controller.sv | 127 ++++++++++++
 tb/tb_mc_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// funct codes, ALU select values and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPEEX  = 4'd6,
    S_RTYPEWB  = 4'd7,
    S_BEQEX    = 4'd8,
    S_BNEEX    = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JEX      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REG   = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// R-type funct decoder: ALU select, shift flag (shamt on the a input) and
// a valid flag for recognised functs.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alusel,
  output logic       shift,
  output logic       valid
);

  always_comb begin
    alusel = ALU_ADD;
    shift  = 1'b0;
    valid  = 1'b1;
    case (funct)
      FN_ADD: alusel = ALU_ADD;
      FN_SUB: alusel = ALU_SUB;
      FN_AND: alusel = ALU_AND;
      FN_OR:  alusel = ALU_OR;
      FN_SLT: alusel = ALU_SLT;
      FN_SLL: begin alusel = ALU_SLL; shift = 1'b1; end
      FN_SRL: begin alusel = ALU_SRL; shift = 1'b1; end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback, driving all datapath selects and write enables.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alusel,
  output logic [1:0] pcsrc,
  output logic       pcen
);

  state_t     state_reg, state_next;
  logic [2:0] dec_sel;
  logic       dec_shift, dec_valid;

  mc_alu_dec u_alu_dec (
    .funct  (funct),
    .alusel (dec_sel),
    .shift  (dec_shift),
    .valid  (dec_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_BNE:       state_next = S_BNEEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_next = S_MEMWB;
      S_RTYPEEX: state_next = dec_valid ? S_RTYPEWB : S_FETCH;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;
    endcase
  end

  // Reset overrides the state so outputs look like a FETCH with enables held low.
  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = SRCA_PC;
    alusrcb  = SRCB_REG;
    alusel   = ALU_ADD;
    pcsrc    = PC_ALU;
    pcen     = 1'b0;
    if (reset) begin
      alusrcb = SRCB_FOUR;
    end else begin
      case (state_reg)
        S_FETCH: begin
          alusrcb = SRCB_FOUR;
          irwrite = 1'b1;
          pcen    = 1'b1;
        end
        S_DECODE: alusrcb = SRCB_IMM_SH;
        S_MEMADR: begin
          alusrca = SRCA_REG;
          alusrcb = SRCB_IMM;
        end
        S_MEMRD: iord = 1'b1;
        S_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        S_MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_RTYPEEX: begin
          alusel  = dec_sel;
          alusrca = dec_shift ? SRCA_SHAMT : SRCA_REG;
        end
        S_RTYPEWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        S_BEQEX, S_BNEEX: begin
          alusrca = SRCA_REG;
          alusel  = ALU_SUB;
          pcsrc   = PC_ALUOUT;
          pcen    = (state_reg == S_BEQEX) ? zero : ~zero;
        end
        S_ADDIEX: begin
          alusrca = SRCA_REG;
          alusrcb = SRCB_IMM;
        end
        S_ADDIWB: regwrite = 1'b1;
        S_JEX: begin
          pcsrc = PC_JUMP;
          pcen  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction cycle tables built
// from the instruction-level behaviour, driven with random operands and aborts.
module tb_mc_controller;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [2:0] sel;
    logic [1:0] pcsrc;
    logic       pcen;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, pcen;
  logic [1:0] alusrca, alusrcb, pcsrc;
  logic [2:0] alusel;
  ctl_t       obs;

  int total = 0;
  int bad   = 0;

  ctl_t exp_q[$];
  ctl_t msk_q[$];

  mc_controller dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .funct    (funct),
    .zero     (zero),
    .iord     (iord),
    .memwrite (memwrite),
    .irwrite  (irwrite),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .regwrite (regwrite),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .alusel   (alusel),
    .pcsrc    (pcsrc),
    .pcen     (pcen)
  );

  always #5 clk = ~clk;

  assign obs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                alusrca, alusrcb, alusel, pcsrc, pcen};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic ctl_t blank();
    ctl_t c;
    c = '0;
    c.sel = 3'b010;
    return c;
  endfunction

  function automatic bit rfun(input logic [5:0] f, output logic [2:0] sel, output bit sh);
    sel = 3'b010;
    sh  = 1'b0;
    case (f)
      6'b100000: sel = 3'b010;
      6'b100010: sel = 3'b110;
      6'b100100: sel = 3'b000;
      6'b100101: sel = 3'b001;
      6'b101010: sel = 3'b111;
      6'b000000: begin sel = 3'b100; sh = 1'b1; end
      6'b000010: begin sel = 3'b101; sh = 1'b1; end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic add(input ctl_t c, input ctl_t m);
    exp_q.push_back(c);
    msk_q.push_back(m);
  endtask

  // Reset view: FETCH selects with every enable held low.
  task automatic hold_reset(input int n, input string tag);
    ctl_t r;
    r = blank();
    r.srcb = 2'b01;
    reset = 1'b1;
    for (int k = 0; k < n; k++) begin
      op    = 6'($urandom_range(0, 63));
      funct = 6'($urandom_range(0, 63));
      zero  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("%s_rst%0d", tag, k), obs, r);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  // zf<0: random zero per cycle; abort_at>=0: assert reset at that cycle for hold cycles.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zf,
                           input int abort_at, input int hold);
    ctl_t  c, full, m;
    logic  zv[6];
    logic [2:0] sel;
    bit    sh, v;
    int    n;
    full = '1;
    exp_q.delete();
    msk_q.delete();
    for (int k = 0; k < 6; k++) zv[k] = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);

    c = blank(); c.srcb = 2'b01; c.irwrite = 1'b1; c.pcen = 1'b1; add(c, full);
    c = blank(); c.srcb = 2'b11; add(c, full);
    case (o)
      6'b100011, 6'b101011: begin
        c = blank(); c.srca = 2'b01; c.srcb = 2'b10; add(c, full);
        if (o == 6'b100011) begin
          c = blank(); c.iord = 1'b1; add(c, full);
          c = blank(); c.memtoreg = 1'b1; c.regwrite = 1'b1; add(c, full);
        end else begin
          c = blank(); c.iord = 1'b1; c.memwrite = 1'b1; add(c, full);
        end
      end
      6'b000000: begin
        v = rfun(f, sel, sh);
        c = blank(); c.sel = sel; c.srca = sh ? 2'b10 : 2'b01;
        m = full;
        if (!v) begin m.srca = 2'b00; m.sel = 3'b000; end
        add(c, m);
        if (v) begin
          c = blank(); c.regdst = 1'b1; c.regwrite = 1'b1; add(c, full);
        end
      end
      6'b000100, 6'b000101: begin
        c = blank(); c.srca = 2'b01; c.sel = 3'b110; c.pcsrc = 2'b01;
        c.pcen = (o == 6'b000100) ? zv[2] : ~zv[2];
        add(c, full);
      end
      6'b001000: begin
        c = blank(); c.srca = 2'b01; c.srcb = 2'b10; add(c, full);
        c = blank(); c.regwrite = 1'b1; add(c, full);
      end
      6'b000010: begin
        c = blank(); c.pcsrc = 2'b10; c.pcen = 1'b1; add(c, full);
      end
      default: ;
    endcase

    n = exp_q.size();
    $display("instr op=%b funct=%b cycles=%0d abort_at=%0d", o, f, n, abort_at);
    for (int k = 0; k < n; k++) begin
      if (k == abort_at) begin
        hold_reset(hold, $sformatf("abort_op%b", o));
        return;
      end
      op    = (k == 0) ? 6'($urandom_range(0, 63)) : o;
      funct = (k == 0) ? 6'($urandom_range(0, 63)) : f;
      zero  = zv[k];
      @(negedge clk);
      check($sformatf("op%b_fn%b_c%0d", o, f, k), obs & msk_q[k], exp_q[k] & msk_q[k]);
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] op_tab[8];
  logic [5:0] fn_tab[8];

  initial begin
    logic [5:0] o, f;
    reset = 1'b1;
    op    = '0;
    funct = '0;
    zero  = 1'b0;
    op_tab = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
               6'b000101, 6'b001000, 6'b000010, 6'b111111};
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
               6'b101010, 6'b000000, 6'b000010, 6'b000111};

    #1;
    hold_reset(3, "init");

    run_instr(6'b100011, 6'b000000, -1, -1, 0);  // lw
    run_instr(6'b101011, 6'b000000, -1, -1, 0);  // sw
    run_instr(6'b000000, 6'b100010, -1, -1, 0);  // sub
    run_instr(6'b000000, 6'b000000, -1, -1, 0);  // sll
    run_instr(6'b000000, 6'b000010, -1, -1, 0);  // srl
    run_instr(6'b000100, 6'b000000,  1, -1, 0);  // beq taken
    run_instr(6'b000100, 6'b000000,  0, -1, 0);  // beq not taken
    run_instr(6'b000101, 6'b000000,  1, -1, 0);  // bne not taken
    run_instr(6'b000101, 6'b000000,  0, -1, 0);  // bne taken
    run_instr(6'b001000, 6'b000000, -1, -1, 0);  // addi
    run_instr(6'b000010, 6'b000000, -1, -1, 0);  // j
    run_instr(6'b111111, 6'b000000, -1, -1, 0);  // unknown opcode
    run_instr(6'b000000, 6'b000111, -1, -1, 0);  // unknown funct
    run_instr(6'b101011, 6'b000000, -1,  3, 3);  // reset during MEMWR
    run_instr(6'b100011, 6'b000000, -1,  3, 1);  // reset during MEMRD
    run_instr(6'b100011, 6'b000000, -1, -1, 0);

    for (int i = 0; i < 80; i++) begin
      o = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : op_tab[$urandom_range(0, 7)];
      f = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : fn_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0)
        run_instr(o, f, -1, $urandom_range(1, 4), $urandom_range(1, 3));
      else
        run_instr(o, f, -1, -1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
